// File: rtl/pcs_synchronize.sv
// 1000BASE-X PCS receive code-group synchronization: comma detection, running disparity,
// even/odd alignment and acquire/lose-sync FSM. Optional macro PCS_SIGNAL_DETECT_EN adds signal_detect.
`timescale 1ns/1ps
module pcs_synchronize #(
    parameter int unsigned GOOD_CGS_MAX = 3,
    localparam int unsigned CG_W = 10
) (
    input  logic            GTX_CLK,
    input  logic            mr_main_reset,
    input  logic [CG_W-1:0] rx_code_group,
`ifdef PCS_SIGNAL_DETECT_EN
    input  logic            signal_detect,
`endif
    output logic            code_sync_status,
    output logic            rx_even,
    output logic [CG_W-1:0] sudi_code_group,
    output logic            sudi_valid,
    output logic            cg_invalid
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GCS_W = 2;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        COMMA_DETECT_2,
        COMMA_DETECT_3,
        ACQUIRE_SYNC_1,
        ACQUIRE_SYNC_2,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4A
    } state_e;

    state_e             state_q, state_d;
    logic               rd_q, rd_d;
    logic               rx_even_q, rx_even_d;
    logic               sync_q, sync_d;
    logic [GCS_W-1:0]   good_cgs_q, good_cgs_d;
    logic [CG_W-1:0]    cg_q;
    logic               valid_q;
    logic               invalid_q;

    logic [CNT_W-1:0]   ones_c;
    logic               comma_c;
    logic               misaligned_c;
    logic               invalid_c;
    logic               cgbad_c;
    logic               data_c;
    logic               sig_det_c;
    logic               gcs_max_c;

    function automatic logic is_comma(input logic [6:0] v);
        return (v == 7'b0011111) || (v == 7'b1100000);
    endfunction

`ifdef PCS_SIGNAL_DETECT_EN
    assign sig_det_c = signal_detect;
`else
    assign sig_det_c = 1'b1;
`endif

    // Code-group classification against the disparity and alignment held before this edge
    assign ones_c       = CNT_W'($countones(rx_code_group));
    assign comma_c      = is_comma(rx_code_group[9:3]);
    assign misaligned_c = is_comma(rx_code_group[8:2]) || is_comma(rx_code_group[7:1]) ||
                          is_comma(rx_code_group[6:0]);
    assign invalid_c    = !(ones_c inside {4'd4, 4'd5, 4'd6}) ||
                          ((ones_c == 4'd6) && rd_q) || ((ones_c == 4'd4) && !rd_q) ||
                          misaligned_c;
    assign cgbad_c      = invalid_c || (comma_c && rx_even_q);
    assign data_c       = !invalid_c && !comma_c;
    assign gcs_max_c    = (32'(good_cgs_q) == GOOD_CGS_MAX);

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        good_cgs_d = good_cgs_q;
        rx_even_d  = !rx_even_q;
        sync_d     = 1'b0;

        if (!invalid_c) begin
            if (ones_c == 4'd6)      rd_d = 1'b1;
            else if (ones_c == 4'd4) rd_d = 1'b0;
        end

        unique case (state_q)
            LOSS_OF_SYNC:     if (comma_c) state_d = COMMA_DETECT_1;
            COMMA_DETECT_1:   state_d = data_c ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2:   state_d = data_c ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3:   state_d = data_c ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (cgbad_c)      state_d = LOSS_OF_SYNC;
                else if (comma_c) state_d = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (cgbad_c)      state_d = LOSS_OF_SYNC;
                else if (comma_c) state_d = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1:  if (cgbad_c) state_d = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2: begin
                state_d    = cgbad_c ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
                good_cgs_d = GCS_W'(1);
            end
            SYNC_ACQUIRED_3: begin
                state_d    = cgbad_c ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
                good_cgs_d = GCS_W'(1);
            end
            SYNC_ACQUIRED_4: begin
                state_d    = cgbad_c ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
                good_cgs_d = GCS_W'(1);
            end
            SYNC_ACQUIRED_2A: begin
                if (cgbad_c)        state_d = SYNC_ACQUIRED_3;
                else if (gcs_max_c) state_d = SYNC_ACQUIRED_1;
                else if (good_cgs_q != '1) good_cgs_d = good_cgs_q + GCS_W'(1);
            end
            SYNC_ACQUIRED_3A: begin
                if (cgbad_c)        state_d = SYNC_ACQUIRED_4;
                else if (gcs_max_c) state_d = SYNC_ACQUIRED_2;
                else if (good_cgs_q != '1) good_cgs_d = good_cgs_q + GCS_W'(1);
            end
            SYNC_ACQUIRED_4A: begin
                if (cgbad_c)        state_d = LOSS_OF_SYNC;
                else if (gcs_max_c) state_d = SYNC_ACQUIRED_3;
                else if (good_cgs_q != '1) good_cgs_d = good_cgs_q + GCS_W'(1);
            end
            default:          state_d = LOSS_OF_SYNC;
        endcase

        if (!sig_det_c) state_d = LOSS_OF_SYNC;

        // Non-A sync-acquired states always start a fresh good-group run
        if (state_d inside {SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4}) good_cgs_d = '0;

        sync_d = state_d inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4,
                                 SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A};

        if (state_d inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3}) rx_even_d = 1'b1;
        else if (sync_d && comma_c)                                          rx_even_d = 1'b1;
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q    <= LOSS_OF_SYNC;
            rd_q       <= 1'b0;
            rx_even_q  <= 1'b0;
            sync_q     <= 1'b0;
            good_cgs_q <= '0;
            cg_q       <= '0;
            valid_q    <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            rx_even_q  <= rx_even_d;
            sync_q     <= sync_d;
            good_cgs_q <= good_cgs_d;
            cg_q       <= rx_code_group;
            valid_q    <= 1'b1;
            invalid_q  <= invalid_c;
        end
    end

    assign code_sync_status = sync_q;
    assign rx_even          = rx_even_q;
    assign sudi_code_group  = cg_q;
    assign sudi_valid       = valid_q;
    assign cg_invalid       = invalid_q;

endmodule

// File: tb/tb_pcs_synchronize.sv
// Self-checking bench for pcs_synchronize: directed vector table, hand-built corner sequences
// and randomized code groups against an abstract synchronization model.
`timescale 1ns/1ps
module tb_pcs_synchronize;

    localparam int unsigned GCM = 3;
    localparam logic [9:0] K28P5N = 10'b0011111010;
    localparam logic [9:0] K28P5P = 10'b1100000101;
    localparam logic [9:0] D162P  = 10'b1001000101;
    localparam logic [9:0] D162N  = 10'b0110110101;
    localparam logic [9:0] D21P5  = 10'b1010101010;
    localparam logic [9:0] ZERO   = 10'b0000000000;
    localparam logic [9:0] MISAL  = 10'b0001111100;

    logic       GTX_CLK;
    logic       mr_main_reset;
    logic [9:0] rx_code_group;
    logic       sd_drv;
    logic       code_sync_status;
    logic       rx_even;
    logic [9:0] sudi_code_group;
    logic       sudi_valid;
    logic       cg_invalid;

    int checks = 0;
    int errors = 0;

    // Abstract reference: acquisition counted in commas, sync quality as a bad-level plus good run
    int       m_rd;
    bit       m_even;
    int       m_commas;
    bit       m_want;
    bit       m_sync;
    int       m_bad;
    int       m_good;
    bit       m_inv;
    bit [9:0] m_cg;
    bit       m_valid;

    pcs_synchronize #(.GOOD_CGS_MAX(GCM)) dut (
        .GTX_CLK          (GTX_CLK),
        .mr_main_reset    (mr_main_reset),
        .rx_code_group    (rx_code_group),
`ifdef PCS_SIGNAL_DETECT_EN
        .signal_detect    (sd_drv),
`endif
        .code_sync_status (code_sync_status),
        .rx_even          (rx_even),
        .sudi_code_group  (sudi_code_group),
        .sudi_valid       (sudi_valid),
        .cg_invalid       (cg_invalid)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    typedef struct {
        logic [9:0] cg;
        logic       sync;
        logic       even;
        logic       inv;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_k7(input logic [6:0] v);
        return (v == 7'b0011111) || (v == 7'b1100000);
    endfunction

    function automatic logic [9:0] k_of(input int rd);
        return (rd < 0) ? K28P5N : K28P5P;
    endfunction

    function automatic logic [9:0] d_of(input int rd);
        return (rd < 0) ? D162N : D162P;
    endfunction

    task automatic model_reset();
        m_rd = -1; m_even = 0; m_commas = 0; m_want = 0; m_sync = 0;
        m_bad = 0; m_good = 0; m_inv = 0; m_cg = '0; m_valid = 0;
    endtask

    task automatic model_step(input logic [9:0] cg, input bit sd);
        int         ones;
        bit         comma, mis, invalid, bad, data;
        logic [9:0] sh;
        ones  = $countones(cg);
        sh    = cg >> 3;
        comma = is_k7(sh[6:0]);
        mis   = 0;
        for (int s = 0; s < 3; s++) begin
            sh = cg >> s;
            if (is_k7(sh[6:0])) mis = 1;
        end
        invalid = (ones < 4) || (ones > 6) || (ones == 6 && m_rd > 0) ||
                  (ones == 4 && m_rd < 0) || mis;
        bad  = invalid || (comma && m_even);
        data = !invalid && !comma;

        if (!m_sync) begin
            if (m_want) begin
                m_want = 0;
                if (!data) m_commas = 0;
                else if (m_commas == 3) begin m_sync = 1; m_bad = 0; m_good = 0; end
            end else if (m_commas == 0) begin
                if (comma) begin m_commas = 1; m_want = 1; end
            end else if (bad) begin
                m_commas = 0;
            end else if (comma) begin
                m_commas++; m_want = 1;
            end
        end else begin
            if (bad) begin
                m_bad++; m_good = 0;
                if (m_bad == 4) begin m_sync = 0; m_commas = 0; m_bad = 0; end
            end else if (m_bad > 0) begin
                if (m_good == GCM) begin m_bad--; m_good = 0; end
                else m_good++;
            end
        end
        if (!sd) begin m_sync = 0; m_commas = 0; m_want = 0; m_bad = 0; m_good = 0; end

        if (m_want)                m_even = 1;
        else if (m_sync && comma)  m_even = 1;
        else                       m_even = !m_even;

        if (!invalid) begin
            if (ones == 6)      m_rd = 1;
            else if (ones == 4) m_rd = -1;
        end
        m_inv = invalid; m_cg = cg; m_valid = 1;
    endtask

    // Drive one group now (off-edge), let one edge sample it, compare 1 ns later
    task automatic step(input logic [9:0] cg);
        rx_code_group = cg;
        @(posedge GTX_CLK);
        model_step(cg, sd_drv);
        #1;
        check("sync",  code_sync_status, 32'(m_sync));
        check("even",  rx_even,          32'(m_even));
        check("inv",   cg_invalid,       32'(m_inv));
        check("sudi",  sudi_code_group,  32'(m_cg));
        check("valid", sudi_valid,       32'(m_valid));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sync"},  code_sync_status, 0);
        check({tag, "_even"},  rx_even,          0);
        check({tag, "_inv"},   cg_invalid,       0);
        check({tag, "_sudi"},  sudi_code_group,  0);
        check({tag, "_valid"}, sudi_valid,       0);
    endtask

    task automatic acquire();
        repeat (3) begin
            step(k_of(m_rd));
            step(d_of(m_rd));
        end
        check("acq_sync", code_sync_status, 1);
    endtask

    initial begin
        logic [9:0] cg;
        int         r;

        tbl[0]  = '{K28P5N, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{D162P,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{K28P5N, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{D162P,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{K28P5N, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{D162P,  1'b1, 1'b0, 1'b0};
        tbl[6]  = '{K28P5N, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{D162P,  1'b1, 1'b0, 1'b0};
        tbl[8]  = '{ZERO,   1'b1, 1'b1, 1'b1};
        tbl[9]  = '{ZERO,   1'b1, 1'b0, 1'b1};
        tbl[10] = '{ZERO,   1'b1, 1'b1, 1'b1};
        tbl[11] = '{ZERO,   1'b0, 1'b0, 1'b1};
        tbl[12] = '{K28P5N, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{D162P,  1'b0, 1'b0, 1'b0};
        tbl[14] = '{D162P,  1'b0, 1'b1, 1'b1};
        tbl[15] = '{K28P5N, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{K28P5N, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{D162P,  1'b0, 1'b1, 1'b0};
        tbl[18] = '{MISAL,  1'b0, 1'b0, 1'b1};

        mr_main_reset = 1'b0;
        rx_code_group = '0;
        sd_drv        = 1'b1;
        model_reset();

        // Held in reset with random input: everything stays at zero
        repeat (3) begin
            @(negedge GTX_CLK);
            rx_code_group = 10'($urandom);
        end
        check_all_zero("rst");
        mr_main_reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].cg);
            check($sformatf("vec%0d_sync", i), code_sync_status, 32'(tbl[i].sync));
            check($sformatf("vec%0d_even", i), rx_even,          32'(tbl[i].even));
            check($sformatf("vec%0d_inv", i),  cg_invalid,       32'(tbl[i].inv));
        end

        // Hysteresis: one bad, four good returns to the top level, then four bad to lose sync
        acquire();
        step(ZERO);        check("hys_b1", code_sync_status, 1);
        step(D21P5);       check("hys_g1", code_sync_status, 1);
        step(k_of(m_rd));  check("hys_g2", code_sync_status, 1);
        step(d_of(m_rd));  check("hys_g3", code_sync_status, 1);
        step(D21P5);       check("hys_g4", code_sync_status, 1);
        step(ZERO);        check("hys_b2", code_sync_status, 1);
        step(ZERO);        check("hys_b3", code_sync_status, 1);
        step(ZERO);        check("hys_b4", code_sync_status, 1);
        step(ZERO);        check("hys_b5", code_sync_status, 0);

        // Mid-stream reset while synced with RD+, then first group must see RD-
        acquire();
        if (m_rd < 0) step(K28P5N);
        #2 mr_main_reset = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        model_reset();
        step(K28P5N);
        check("post_rst_inv",   cg_invalid, 0);
        check("post_rst_valid", sudi_valid, 1);

`ifdef PCS_SIGNAL_DETECT_EN
        acquire();
        sd_drv = 1'b0;
        step(k_of(m_rd));
        check("sd_drop", code_sync_status, 0);
        sd_drv = 1'b1;
`endif

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                10:      cg = D21P5;
                11:      cg = ZERO;
                12:      cg = 10'($urandom);
                13:      cg = k_of(m_rd);
                14:      cg = d_of(m_rd);
                15:      cg = MISAL;
                default: cg = m_even ? d_of(m_rd) : k_of(m_rd);
            endcase
`ifdef PCS_SIGNAL_DETECT_EN
            sd_drv = ($urandom_range(0, 63) != 0);
`endif
            step(cg);
            if ($urandom_range(0, 299) == 0) begin
                #2 mr_main_reset = 1'b0;
                #1 check("rnd_rst_sync", code_sync_status, 0);
                @(negedge GTX_CLK);
                mr_main_reset = 1'b1;
                model_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_synchronize.md
# pcs_synchronize

PCS receive-side code-group synchronization stage for the 1000BASE-X PCS. It sits directly downstream of the transmit/encode path across the link and directly upstream of the PCS receive state machine. It consumes one 10-bit code group per clock, locates commas, tracks running disparity and even/odd alignment, and runs the acquire/lose-sync state machine. It forwards each code group with `rx_even` and `code_sync_status` as the SUDI stream.

## Interface
- `GOOD_CGS_MAX`, default 3: consecutive good code groups in an xA state that retire one bad-count level.
- `GTX_CLK`  in  1  receive code-group clock; every rising edge samples one code group.
- `mr_main_reset`  in  1  asynchronous, active-low reset.
- `rx_code_group`  in  10  received code group; bit 9 = `a` (first transmitted), bit 0 = `j`.
- `signal_detect`  in  1  PMD signal present (only with `PCS_SIGNAL_DETECT_EN`).
- `code_sync_status`  out  1  1 = synchronized.
- `rx_even`  out  1  alignment of the code group in `sudi_code_group`.
- `sudi_code_group`  out  10  registered copy of the sampled code group.
- `sudi_valid`  out  1  pulses 1 each cycle after reset release.
- `cg_invalid`  out  1  sampled code group failed the validity check (diagnostic).

## Operation
- **Comma:** `rx_code_group[9:3]` is `7'b0011111` or `7'b1100000`.
- **Running disparity (RD):** resets to RD−. A valid group with 6 ones sets RD+. A valid group with 4 ones sets RD−. A valid group with 5 ones leaves RD unchanged. An invalid group leaves RD unchanged.
- **Invalid group:** any of the following.
  - Ones count is not 4, 5 or 6.
  - 6 ones while RD+.
  - 4 ones while RD−.
  - Comma pattern at `rx_code_group[8:2]` or lower (misaligned comma).
- **cgbad:** invalid, OR (comma AND current `rx_even`=1).
- **cggood:** not cgbad.
- **data:** valid and not comma.
- **State machine:** states LOSS_OF_SYNC, COMMA_DETECT_1/2/3, ACQUIRE_SYNC_1/2, SYNC_ACQUIRED_1, SYNC_ACQUIRED_2/3/4, SYNC_ACQUIRED_2A/3A/4A. Reset state is LOSS_OF_SYNC.
  - **LOSS_OF_SYNC:** `rx_even` toggles. Comma → COMMA_DETECT_1; else stay.
  - **COMMA_DETECT_n:** entry sets `rx_even`=1. Next group data → ACQUIRE_SYNC_n (n=3 → SYNC_ACQUIRED_1); else → LOSS_OF_SYNC.
  - **ACQUIRE_SYNC_n:** `rx_even` toggles. cgbad → LOSS_OF_SYNC. Comma (with `rx_even`=0) → COMMA_DETECT_n+1. Other cggood → stay.
  - **SYNC_ACQUIRED_1:** cggood → stay; cgbad → SYNC_ACQUIRED_2.
  - **SYNC_ACQUIRED_n** (n=2,3,4): entry clears good_cgs. cggood → nA with good_cgs=1. cgbad → n+1 (4 → LOSS_OF_SYNC).
  - **nA:** cgbad → n+1 (4A → LOSS_OF_SYNC). cggood with good_cgs=`GOOD_CGS_MAX` → n−1 (2A → SYNC_ACQUIRED_1). Other cggood → good_cgs+1, stay.
  - In every SYNC_ACQUIRED state, `rx_even` toggles each group, except that a comma forces `rx_even`=1.
- `code_sync_status` is 1 in every SYNC_ACQUIRED* state and 0 elsewhere.
- good_cgs is 2 bits wide and saturates.

## Timing
- **Reset (async assert, sync release):** state=LOSS_OF_SYNC, RD−, `rx_even`=0, `code_sync_status`=0, `sudi_code_group`=0, `sudi_valid`=0, `cg_invalid`=0.
- **Latency:** one cycle. On edge k the block samples a code group, updates state and RD, and registers `sudi_code_group`, `rx_even`, `code_sync_status` and `cg_invalid` from that edge's next-state values.
- cgbad/cggood for edge k use the `rx_even` and RD values held before edge k.
- Reset asserted mid-stream returns all outputs to reset values immediately. The first group after release is evaluated against RD−.

## Configuration
- **`PCS_SIGNAL_DETECT_EN` defined:** `signal_detect` port exists. `signal_detect`=0 forces LOSS_OF_SYNC on the next edge from any state, with `code_sync_status`=0. The comma transition out of LOSS_OF_SYNC also requires `signal_detect`=1.
- **Not defined:** port absent; signal_detect is treated as constant 1.

## Test plan
- **Reset:** hold `mr_main_reset`=0 with random input → all outputs 0. After release, `sudi_valid`=1 on the first edge.
- **Acquire:** feed 3× (K28.5− `0011111010`, D16.2+ `1001000101`) → `code_sync_status` rises on the edge sampling the 3rd D16.2 (6th group). `rx_even`=1 on K28.5 groups.
- **Odd comma:** K28.5−, D16.2+, D16.2+, K28.5− → `cg_invalid`=1 on the 3rd group (D16.2+ with 4 ones while RD−). State returns to LOSS_OF_SYNC with `code_sync_status` held at 0.
- **Loss:** from sync, 4× `0000000000` → `cg_invalid`=1 each. `code_sync_status` falls on the edge sampling the 4th.
- **Hysteresis:** from sync, 1 bad, 4 good /I2/ groups (back to SYNC_ACQUIRED_1), then 3 bad → `code_sync_status` stays 1. One more bad → falls to 0.
- **Disparity / mid-reset:** K28.5− twice in a row → 2nd flagged `cg_invalid`. Pulse reset while synced → `code_sync_status`=0 asynchronously. With `PCS_SIGNAL_DETECT_EN`, `signal_detect`=0 while synced → 0 on the next edge.
